// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage for the tp4 pipeline: issues sequential
// fetches to a 1-cycle synchronous memory and buffers the words in a FWFT queue for decode.
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       PC_STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned       FQ_DEPTH     = 4,
    parameter logic [DATA_W-1:0] HALT_WORD    = '1
) (
    input  logic                            clk,
    input  logic                            pc_reset_n,
    input  logic                            pc_enable,
    input  logic                            pc_step,
    output logic                            imem_req,
    output logic [ADDR_W-1:0]               imem_addr,
    input  logic [DATA_W-1:0]               imem_rdata,
    input  logic                            redir_valid,
    input  logic [ADDR_W-1:0]               redir_target,
    output logic                            if_valid,
    input  logic                            if_ready,
    output logic [DATA_W-1:0]               if_instr,
    output logic [ADDR_W-1:0]               if_pc,
    output logic [ADDR_W-1:0]               if_pc_next,
    output logic                            halted,
    output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
);
    localparam int unsigned       CNT_W = $clog2(FQ_DEPTH + 1);
    localparam int unsigned       PTR_W = $clog2(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              step_pending_q, step_pending_d;
    logic              halted_q, halted_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] fq_instr_q [FQ_DEPTH];
    logic [ADDR_W-1:0] fq_pc_q    [FQ_DEPTH];

    logic halt_hit;
    logic has_credit;
    logic issue;
    logic enq;
    logic pop;

    always_comb begin
        halt_hit   = inflight_q && (imem_rdata == HALT_WORD);
        // The in-flight word already owns a slot; a same-cycle pop does not free one.
        has_credit = (({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FQ_DEPTH));
        issue      = pc_reset_n && (pc_enable || step_pending_q) && !halted_q
                     && !redir_valid && has_credit && !halt_hit;
        enq        = inflight_q && !redir_valid;
        pop        = (count_q != '0) && if_ready;

        pc_d           = pc_q;
        inflight_d     = inflight_q;
        inflight_pc_d  = inflight_pc_q;
        step_pending_d = step_pending_q;
        halted_d       = halted_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;

        if (redir_valid) begin
            pc_d           = redir_target;
            inflight_d     = 1'b0;
            step_pending_d = 1'b0;
            halted_d       = 1'b0;
            rd_ptr_d       = '0;
            wr_ptr_d       = '0;
            count_d        = '0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                pc_d          = pc_q + STEP;
                inflight_pc_d = pc_q;
            end
            if (issue) begin
                step_pending_d = 1'b0;
            end else if (pc_step && !pc_enable) begin
                step_pending_d = 1'b1;
            end
            if (halt_hit) begin
                halted_d = 1'b1;
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            pc_q           <= RESET_VECTOR;
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
            step_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            pc_q           <= pc_d;
            inflight_q     <= inflight_d;
            inflight_pc_q  <= inflight_pc_d;
            step_pending_q <= step_pending_d;
            halted_q       <= halted_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
        end
    end

    // Queue storage needs no reset: head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            fq_instr_q[wr_ptr_q] <= imem_rdata;
            fq_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assign imem_req   = issue;
    assign imem_addr  = pc_q;
    assign if_valid   = (count_q != '0);
    assign if_instr   = if_valid ? fq_instr_q[rd_ptr_q] : '0;
    assign if_pc      = if_valid ? fq_pc_q[rd_ptr_q] : '0;
    assign if_pc_next = if_pc + STEP;
    assign halted     = halted_q;
    assign fq_count   = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed latency scenarios plus randomized traffic checked
// against an in-order address-stream model of fetches and deliveries.
module tb_pc_fetch_unit;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int PC_STEP  = 4;
    localparam int FQ_DEPTH = 4;
    localparam int CNT_W    = $clog2(FQ_DEPTH + 1);
    localparam logic [ADDR_W-1:0] RV   = 32'h0000_0040;
    localparam logic [DATA_W-1:0] HALT = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              pc_reset_n;
    logic              pc_enable;
    logic              pc_step;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_target;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_pc_next;
    logic              halted;
    logic [CNT_W-1:0]  fq_count;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_STEP(PC_STEP),
        .RESET_VECTOR(RV), .FQ_DEPTH(FQ_DEPTH), .HALT_WORD(HALT)
    ) dut (
        .clk(clk), .pc_reset_n(pc_reset_n), .pc_enable(pc_enable), .pc_step(pc_step),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_next(if_pc_next), .halted(halted), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: word = its own address, except one optional HALT location.
    logic              halt_en = 1'b0;
    logic [ADDR_W-1:0] halt_addr = 32'h10;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (halt_en && a == halt_addr) return HALT;
        return DATA_W'(a);
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= DATA_W'($urandom) & 32'h7FFF_FFFC;
    end

    // Reference model: decode must see consecutive addresses from the last reset/redirect.
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] fill_addr;

    function automatic void model_top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(fill_addr);
            fill_addr = fill_addr + ADDR_W'(PC_STEP);
        end
    endfunction

    function automatic void model_restart(input logic [ADDR_W-1:0] a);
        exp_q.delete();
        fill_addr = a;
        model_top_up();
    endfunction

    task automatic set_inputs(input logic en, input logic stp, input logic rdy,
                              input logic rv, input logic [ADDR_W-1:0] tgt);
        pc_enable    = en;
        pc_step      = stp;
        if_ready     = rdy;
        redir_valid  = rv;
        redir_target = tgt;
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
        pc_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: req=%b valid=%b halted=%b, expected 0 0 0", imem_req, if_valid, halted);
        end
        checks++;
        if (imem_addr !== RV) begin
            failures++;
            $display("FAIL reset_addr: imem_addr=%h, expected %h", imem_addr, RV);
        end
        checks++;
        if (if_instr !== '0 || if_pc !== '0 || fq_count !== '0) begin
            failures++;
            $display("FAIL reset_head: instr=%h pc=%h count=%0d, expected 0 0 0", if_instr, if_pc, fq_count);
        end
        checks++;
        if (if_pc_next !== ADDR_W'(PC_STEP)) begin
            failures++;
            $display("FAIL reset_pc_next: if_pc_next=%h, expected %h", if_pc_next, PC_STEP);
        end
        @(negedge clk);
        pc_reset_n = 1'b1;
    endtask

    // Fresh start (reset just released): issue every cycle, data from cycle 2 on.
    task automatic test_stream(input logic [ADDR_W-1:0] start, input int ncyc, input string tag);
        logic [ADDR_W-1:0] exp_a;
        model_restart(start);
        for (int c = 0; c < ncyc; c++) begin
            set_inputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
            #2;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== start + ADDR_W'(PC_STEP * c)) begin
                failures++;
                $display("FAIL %s_issue c=%0d: req=%b addr=%h, expected 1 %h", tag, c, imem_req,
                         imem_addr, start + ADDR_W'(PC_STEP * c));
            end
            checks++;
            if (if_valid !== (c >= 2)) begin
                failures++;
                $display("FAIL %s_valid c=%0d: if_valid=%b, expected %b", tag, c, if_valid, (c >= 2));
            end
            if (if_valid && if_ready) begin
                exp_a = exp_q.pop_front();
                model_top_up();
                checks++;
                if (if_pc !== exp_a || if_instr !== mem_word(exp_a) || if_pc_next !== exp_a + ADDR_W'(PC_STEP)) begin
                    failures++;
                    $display("FAIL %s_head: pc=%h instr=%h next=%h, expected pc=%h instr=%h next=%h", tag,
                             if_pc, if_instr, if_pc_next, exp_a, mem_word(exp_a), exp_a + ADDR_W'(PC_STEP));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] exp_a;
        for (int c = 0; c < 10; c++) begin
            set_inputs(1'b1, 1'b0, 1'b0, 1'b0, '0);
            #2;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== exp_q[0] || if_instr !== mem_word(exp_q[0])) begin
                failures++;
                $display("FAIL stall_hold c=%0d: valid=%b pc=%h instr=%h, expected 1 %h %h", c, if_valid,
                         if_pc, if_instr, exp_q[0], mem_word(exp_q[0]));
            end
            checks++;
            if (fq_count !== CNT_W'((c < 3) ? c + 1 : FQ_DEPTH) || imem_req !== (c < 2)) begin
                failures++;
                $display("FAIL stall_fill c=%0d: count=%0d req=%b, expected %0d %b", c, fq_count, imem_req,
                         (c < 3) ? c + 1 : FQ_DEPTH, (c < 2));
            end
            @(negedge clk);
        end
        for (int c = 0; c < 12; c++) begin
            set_inputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
            #2;
            checks++;
            if (if_valid !== 1'b1 || fq_count > FQ_DEPTH) begin
                failures++;
                $display("FAIL resume_valid c=%0d: valid=%b count=%0d, expected 1 and count<=%0d", c,
                         if_valid, fq_count, FQ_DEPTH);
            end
            if (if_valid && if_ready) begin
                exp_a = exp_q.pop_front();
                model_top_up();
                checks++;
                if (if_pc !== exp_a || if_instr !== mem_word(exp_a)) begin
                    failures++;
                    $display("FAIL resume_head: pc=%h instr=%h, expected %h %h", if_pc, if_instr, exp_a, mem_word(exp_a));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        logic [ADDR_W-1:0] exp_a;
        logic              exp_req;
        logic [ADDR_W-1:0] exp_addr;
        set_inputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
        pc_reset_n = 1'b0;
        @(negedge clk);
        pc_reset_n = 1'b1;
        model_restart(RV);
        for (int c = 0; c < 15; c++) begin
            set_inputs(1'b1, 1'b0, 1'b1, (c == 6), 32'h100);
            #2;
            exp_req  = (c != 6);
            exp_addr = (c < 6) ? RV + ADDR_W'(PC_STEP * c) : 32'h100 + ADDR_W'(PC_STEP * (c - 7));
            checks++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin
                failures++;
                $display("FAIL redir_issue c=%0d: req=%b addr=%h, expected %b %h", c, imem_req, imem_addr, exp_req, exp_addr);
            end
            checks++;
            if (if_valid !== ((c >= 2 && c <= 6) || c >= 9)) begin
                failures++;
                $display("FAIL redir_valid c=%0d: if_valid=%b, expected %b", c, if_valid, ((c >= 2 && c <= 6) || c >= 9));
            end
            if (c == 9) begin
                checks++;
                if (if_pc !== 32'h100) begin
                    failures++;
                    $display("FAIL redir_first: if_pc=%h, expected 00000100", if_pc);
                end
            end
            if (if_valid && if_ready) begin
                exp_a = exp_q.pop_front();
                model_top_up();
                checks++;
                if (if_pc !== exp_a || if_instr !== mem_word(exp_a)) begin
                    failures++;
                    $display("FAIL redir_head: pc=%h instr=%h, expected %h %h", if_pc, if_instr, exp_a, mem_word(exp_a));
                end
            end
            if (redir_valid) model_restart(32'h100);
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        logic [ADDR_W-1:0] exp_a;
        int                n_del;
        n_del = 0;
        halt_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            set_inputs(1'b1, 1'b0, 1'b1, (c == 0 || c == 12), '0);
            if (c == 12) halt_en = 1'b0;
            #2;
            if (c >= 1 && c <= 11) begin
                checks++;
                if (imem_req !== (c <= 5) || (c <= 5 && imem_addr !== ADDR_W'(PC_STEP * (c - 1)))) begin
                    failures++;
                    $display("FAIL halt_issue c=%0d: req=%b addr=%h, expected %b %h", c, imem_req, imem_addr,
                             (c <= 5), PC_STEP * (c - 1));
                end
                checks++;
                if (if_valid !== (c >= 3 && c <= 7) || halted !== (c >= 7)) begin
                    failures++;
                    $display("FAIL halt_state c=%0d: valid=%b halted=%b, expected %b %b", c, if_valid, halted,
                             (c >= 3 && c <= 7), (c >= 7));
                end
            end
            if (c >= 7 && c <= 11) begin
                checks++;
                if (imem_addr !== 32'h14) begin
                    failures++;
                    $display("FAIL halt_pc c=%0d: imem_addr=%h, expected 00000014", c, imem_addr);
                end
            end
            if (c == 0 || c == 12) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL halt_redir_req c=%0d: imem_req=%b, expected 0", c, imem_req);
                end
            end
            if (c == 13) begin
                checks++;
                if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== '0) begin
                    failures++;
                    $display("FAIL halt_clear: halted=%b req=%b addr=%h, expected 0 1 0", halted, imem_req, imem_addr);
                end
            end
            if (if_valid && if_ready) begin
                exp_a = exp_q.pop_front();
                model_top_up();
                if (c >= 1 && c <= 11) n_del++;
                checks++;
                if (if_pc !== exp_a || if_instr !== mem_word(exp_a)) begin
                    failures++;
                    $display("FAIL halt_head: pc=%h instr=%h, expected %h %h", if_pc, if_instr, exp_a, mem_word(exp_a));
                end
            end
            if (redir_valid) model_restart('0);
            @(negedge clk);
        end
        checks++;
        if (n_del != 5) begin
            failures++;
            $display("FAIL halt_count: delivered=%0d, expected 5", n_del);
        end
    endtask

    task automatic test_step();
        logic [ADDR_W-1:0] exp_a;
        logic              stp;
        logic              exp_req;
        int                n_fetch;
        int                n_del;
        n_fetch = 0;
        n_del   = 0;
        for (int c = 0; c < 30; c++) begin
            stp = (c == 2 || c == 7 || c == 12 || c == 17 || c == 18);
            set_inputs(1'b0, stp, 1'b1, (c == 0), '0);
            #2;
            exp_req = (c == 3 || c == 8 || c == 13 || c == 18);
            checks++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== ADDR_W'(PC_STEP * n_fetch))) begin
                failures++;
                $display("FAIL step_issue c=%0d: req=%b addr=%h, expected %b %h", c, imem_req, imem_addr,
                         exp_req, PC_STEP * n_fetch);
            end
            if (exp_req) n_fetch++;
            if (if_valid && if_ready) begin
                exp_a = exp_q.pop_front();
                model_top_up();
                if (c >= 1) n_del++;
                checks++;
                if (if_pc !== exp_a || if_instr !== mem_word(exp_a)) begin
                    failures++;
                    $display("FAIL step_head: pc=%h instr=%h, expected %h %h", if_pc, if_instr, exp_a, mem_word(exp_a));
                end
            end
            if (redir_valid) model_restart('0);
            @(negedge clk);
        end
        checks++;
        if (n_del != 4) begin
            failures++;
            $display("FAIL step_count: delivered=%0d, expected 4", n_del);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_a;
        logic [ADDR_W-1:0] base;
        base = 32'hFFFF_FFF8;
        for (int c = 0; c < 10; c++) begin
            set_inputs(1'b1, 1'b0, 1'b1, (c == 0), base);
            #2;
            if (c >= 1 && c <= 4) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== base + ADDR_W'(PC_STEP * (c - 1))) begin
                    failures++;
                    $display("FAIL wrap_issue c=%0d: req=%b addr=%h, expected 1 %h", c, imem_req, imem_addr,
                             base + ADDR_W'(PC_STEP * (c - 1)));
                end
            end
            if (if_valid && if_ready) begin
                exp_a = exp_q.pop_front();
                model_top_up();
                checks++;
                if (if_pc !== exp_a || if_pc_next !== exp_a + ADDR_W'(PC_STEP)) begin
                    failures++;
                    $display("FAIL wrap_head: pc=%h next=%h, expected %h %h", if_pc, if_pc_next, exp_a, exp_a + ADDR_W'(PC_STEP));
                end
            end
            if (redir_valid) model_restart(base);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 4; c++) begin
            set_inputs(1'b1, 1'b0, 1'b0, 1'b0, '0);
            @(negedge clk);
        end
        #2;
        pc_reset_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || halted !== 1'b0 || fq_count !== '0) begin
            failures++;
            $display("FAIL midreset_flags: req=%b valid=%b halted=%b count=%0d, expected all 0", imem_req,
                     if_valid, halted, fq_count);
        end
        checks++;
        if (imem_addr !== RV || if_pc !== '0 || if_instr !== '0 || if_pc_next !== ADDR_W'(PC_STEP)) begin
            failures++;
            $display("FAIL midreset_values: addr=%h pc=%h instr=%h next=%h, expected %h 0 0 %h", imem_addr,
                     if_pc, if_instr, if_pc_next, RV, PC_STEP);
        end
        @(negedge clk);
        @(negedge clk);
        pc_reset_n = 1'b1;
        test_stream(RV, 10, "restart");
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] exp_a;
        logic [ADDR_W-1:0] tgt;
        logic [ADDR_W-1:0] iss_next;
        logic              en, stp, rdy, rv;
        iss_next = '0;
        for (int c = 0; c < 400; c++) begin
            en  = ($urandom_range(0, 9) != 0);
            stp = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = (c == 0) || ($urandom_range(0, 29) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : (ADDR_W'($urandom) & 32'h0000_FFFC);
            set_inputs(en, stp, rdy, rv, tgt);
            #2;
            checks++;
            if (fq_count > FQ_DEPTH || if_valid !== (fq_count != '0)) begin
                failures++;
                $display("FAIL rnd_count c=%0d: count=%0d valid=%b, expected count<=%0d and valid=(count!=0)", c,
                         fq_count, if_valid, FQ_DEPTH);
            end
            if (fq_count == FQ_DEPTH || rv) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_no_issue c=%0d: imem_req=%b, expected 0", c, imem_req);
                end
            end
            if (imem_req === 1'b1 && !rv) begin
                checks++;
                if (imem_addr !== iss_next) begin
                    failures++;
                    $display("FAIL rnd_issue_addr c=%0d: imem_addr=%h, expected %h", c, imem_addr, iss_next);
                end
            end
            if (c > 0) begin
                checks++;
                if (halted !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_halted c=%0d: halted=%b, expected 0", c, halted);
                end
            end
            if (if_valid && if_ready) begin
                exp_a = exp_q.pop_front();
                model_top_up();
                checks++;
                if (if_pc !== exp_a || if_instr !== mem_word(exp_a) || if_pc_next !== exp_a + ADDR_W'(PC_STEP)) begin
                    failures++;
                    $display("FAIL rnd_head c=%0d: pc=%h instr=%h next=%h, expected %h %h %h", c, if_pc, if_instr,
                             if_pc_next, exp_a, mem_word(exp_a), exp_a + ADDR_W'(PC_STEP));
                end
            end
            if (rv) begin
                model_restart(tgt);
                iss_next = tgt;
            end else if (imem_req === 1'b1) begin
                iss_next = iss_next + ADDR_W'(PC_STEP);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        pc_reset_n = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, '0);
        model_restart(RV);
        @(negedge clk);
        test_reset();
        test_stream(RV, 20, "stream");
        test_backpressure();
        test_redirect();
        test_halt();
        test_step();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
